// File: rtl/par_link_pkg.sv
// Shared definitions for the serial parity link (transmitter and checker side).
// Holds the frame state encoding, parity-sense constants and the default word width.
// No logic; types and constants only.
package par_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } tx_state_t;

  localparam logic PAR_ODD   = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam int   PAR_W_DEF = 8;

endpackage

// File: rtl/par_ser_tx.sv
// Serial parity transmitter: W data bits, one per clock, followed by one parity bit.
// Latency: first data bit on ser_out one cycle after the accept edge; frame is W+1 cycles.
// Backpressure: din_ready only in IDLE or on the parity cycle, so frames can run back to back.
module par_ser_tx
  import par_link_pkg::*;
#(
  parameter int   W         = PAR_W_DEF,
  parameter logic ODD       = PAR_ODD,
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         par_bit
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh_q, sh_d;
  logic          par_q, par_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_valid_q, ser_valid_d;
  logic          par_bit_q, par_bit_d;
  logic          accept;

  // A word may enter only when no data bits are in flight; reset blocks acceptance.
  assign din_ready = ((state_q == IDLE) || (state_q == PAR)) && !rst;
  assign accept    = din_valid && din_ready;

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign par_bit   = par_bit_q;

  // Next-state and registered-output logic. The shift register holds the bits
  // still to be sent: the current bit is already in ser_out_q, so on load the
  // word is stored pre-shifted by one position.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    par_d       = par_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    par_bit_d   = 1'b0;

    case (state_q)
      IDLE, PAR: begin
        if (accept) begin
          state_d     = DATA;
          cnt_d       = '0;
          ser_valid_d = 1'b1;
          par_d       = ODD ? ~^din : ^din;
          if (MSB_FIRST) begin
            ser_out_d = din[W-1];
            sh_d      = din << 1;
          end else begin
            ser_out_d = din[0];
            sh_d      = din >> 1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        ser_valid_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = PAR;
          ser_out_d = par_q;
          par_bit_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (MSB_FIRST) begin
            ser_out_d = sh_q[W-1];
            sh_d      = sh_q << 1;
          end else begin
            ser_out_d = sh_q[0];
            sh_d      = sh_q >> 1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      par_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      par_bit_q   <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_par_ser_tx.sv
// Directed bench for par_ser_tx: three instances (odd/LSB, even/LSB, odd/MSB),
// table-driven single frames plus back-to-back, reset and streaming loopback sequences.
module tb_par_ser_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       dr  [3];
  logic       so  [3];
  logic       sv  [3];
  logic       pb  [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  par_ser_tx #(.W(8), .ODD(1'b1), .MSB_FIRST(1'b0)) u_odd_lsb (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(dr[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .par_bit(pb[0]));

  par_ser_tx #(.W(8), .ODD(1'b0), .MSB_FIRST(1'b0)) u_even_lsb (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(dr[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .par_bit(pb[1]));

  par_ser_tx #(.W(8), .ODD(1'b1), .MSB_FIRST(1'b1)) u_odd_msb (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(dr[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .par_bit(pb[2]));

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // exp[i] is the i-th bit on the line; exp[8] is the parity bit.
  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [8:0] exp;
  } vec_t;

  task automatic send_frame(input int sel, input logic [7:0] d, input logic [8:0] exp,
                            input string name);
    @(negedge clk);
    din[sel] = d;
    dv[sel]  = 1'b1;
    chk({name, ".rdy_before"}, dr[sel], 1'b1);
    @(negedge clk);
    dv[sel] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s.valid[%0d]", name, i), sv[sel], 1'b1);
      chk($sformatf("%s.bit[%0d]", name, i), so[sel], exp[i]);
      chk($sformatf("%s.par_bit[%0d]", name, i), pb[sel], 1'(i == 8));
      if (i < 8) chk($sformatf("%s.rdy_busy[%0d]", name, i), dr[sel], 1'b0);
      @(negedge clk);
    end
    chk({name, ".idle_valid"}, sv[sel], 1'b0);
    chk({name, ".idle_out"}, so[sel], 1'b0);
    chk({name, ".idle_rdy"}, dr[sel], 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [9];
    logic [17:0] exp18;
    int          frames;
    int          bcnt;
    logic        acc;
    bit          pending;
    bit          started;

    tbl[0] = '{0, 8'hA5, 9'h1A5};  // odd, LSB: 1,0,1,0,0,1,0,1 then 1
    tbl[1] = '{0, 8'h07, 9'h007};  // 3 ones -> parity 0
    tbl[2] = '{0, 8'h00, 9'h100};  // 0 ones -> parity 1
    tbl[3] = '{0, 8'hFF, 9'h1FF};  // 8 ones -> parity 1
    tbl[4] = '{1, 8'hA5, 9'h0A5};  // even sense -> parity 0
    tbl[5] = '{1, 8'h00, 9'h000};
    tbl[6] = '{1, 8'h07, 9'h107};  // even sense, 3 ones -> parity 1
    tbl[7] = '{2, 8'hA5, 9'h1A5};  // MSB first, A5 is bit-symmetric
    tbl[8] = '{2, 8'h01, 9'h080};  // MSB first: seven 0s, 1, parity 0

    for (int s = 0; s < 3; s++) begin
      din[s] = 8'h00;
      dv[s]  = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset.valid[%0d]", s), sv[s], 1'b0);
      chk($sformatf("reset.out[%0d]", s), so[s], 1'b0);
      chk($sformatf("reset.par_bit[%0d]", s), pb[s], 1'b0);
      chk($sformatf("reset.rdy_in_rst[%0d]", s), dr[s], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("reset.rdy_after[%0d]", s), dr[s], 1'b1);

    // Single frames from the table
    for (int k = 0; k < 9; k++)
      send_frame(tbl[k].sel, tbl[k].d, tbl[k].exp, $sformatf("vec%0d", k));

    // Back-to-back: A5 then 3C with din_valid held high
    exp18 = {9'h13C, 9'h1A5};
    @(negedge clk);
    din[0] = 8'hA5;
    dv[0]  = 1'b1;
    @(negedge clk);
    din[0] = 8'h3C;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("b2b.valid[%0d]", i), sv[0], 1'b1);
      chk($sformatf("b2b.bit[%0d]", i), so[0], exp18[i]);
      chk($sformatf("b2b.par_bit[%0d]", i), pb[0], 1'(i == 8 || i == 17));
      if (i == 8) chk("b2b.rdy_on_parity", dr[0], 1'b1);
      if (i == 9) dv[0] = 1'b0;
      @(negedge clk);
    end
    chk("b2b.idle_valid", sv[0], 1'b0);
    chk("b2b.idle_rdy", dr[0], 1'b1);

    // Reset during data bit 4 of A5
    @(negedge clk);
    din[0] = 8'hA5;
    dv[0]  = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid.bit4", so[0], 1'b0);
    chk("rstmid.valid_bit4", sv[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid.rdy_rst_high", dr[0], 1'b0);
    @(negedge clk);
    chk("rstmid.valid_after", sv[0], 1'b0);
    chk("rstmid.out_after", so[0], 1'b0);
    chk("rstmid.par_bit_after", pb[0], 1'b0);
    chk("rstmid.rdy_idle_rst", dr[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("rstmid.rdy_release", dr[0], 1'b1);
    send_frame(0, 8'h5A, 9'h15A, "after_rst");

    // Reset together with din_valid must not accept
    @(negedge clk);
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    rst    = 1'b1;
    #1;
    chk("rstvld.rdy", dr[0], 1'b0);
    @(negedge clk);
    dv[0] = 1'b0;
    rst   = 1'b0;
    chk("rstvld.no_accept", sv[0], 1'b0);
    @(negedge clk);
    chk("rstvld.still_idle", sv[0], 1'b0);

    // Streaming loopback: 200 random words, odd-parity accumulation per frame
    frames  = 0;
    bcnt    = 0;
    acc     = 1'b0;
    started = 1'b0;
    @(negedge clk);
    din[0]  = 8'($urandom);
    dv[0]   = 1'b1;
    pending = dr[0];
    for (int cyc = 0; cyc < 2200 && frames < 200; cyc++) begin
      @(negedge clk);
      if (pending) din[0] = 8'($urandom);
      if (started) chk("stream.no_gap", sv[0], 1'b1);
      if (sv[0]) begin
        started = 1'b1;
        acc     = (bcnt == 0) ? so[0] : (acc ^ so[0]);
        bcnt++;
        if (bcnt == 9) begin
          chk($sformatf("stream.par_bit[%0d]", frames), pb[0], 1'b1);
          chk($sformatf("stream.acc[%0d]", frames), acc, 1'b1);
          bcnt = 0;
          frames++;
        end else begin
          chk("stream.par_bit_low", pb[0], 1'b0);
        end
      end
      pending = dr[0];
    end
    dv[0] = 1'b0;
    n_vec++;
    if (frames != 200) begin
      n_err++;
      $display("FAIL stream.frames: got %0d frames, expected 200", frames);
    end
    repeat (2) @(negedge clk);
    chk("stream.drained", sv[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
